// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the CPU data-port to AXI4-Lite bridge.
//   bridge_state_t  : bridge FSM state encoding
//   AXI_RESP_*      : AXI4-Lite response codes
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } bridge_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_data_bridge.sv
// -----------------------------------------------------------------------------
// axil_data_bridge
// Converts the CPU core's BRAM-style data port into single-beat AXI4-Lite
// transactions, one at a time. Completion is signalled by a one-cycle
// data_ready pulse (with data_err) so the core can stall until it arrives.
//
// Ports
//   aclk, areset        : clock, asynchronous active-high reset
//   addr_data           : request byte address (word aligned internally)
//   data_out_data       : write data from the core
//   we_data             : byte enables, nonzero = write, zero = read
//   en_data             : request strobe, only looked at in IDLE
//   data_in_data        : registered read data back to the core
//   data_ready          : one-cycle completion pulse
//   data_err            : response was not OKAY (valid with data_ready)
//   busy                : transaction in flight
//   aw*/w*/b*/ar*/r*    : AXI4-Lite master channels
// -----------------------------------------------------------------------------
module axil_data_bridge
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  // CPU data port
  input  logic [ADDR_W-1:0]     addr_data,
  input  logic [DATA_W-1:0]     data_out_data,
  input  logic [DATA_W/8-1:0]   we_data,
  input  logic                  en_data,
  output logic [DATA_W-1:0]     data_in_data,
  output logic                  data_ready,
  output logic                  data_err,
  output logic                  busy,
  // AXI write address
  output logic [ADDR_W-1:0]     awaddr,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  // AXI write data
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  // AXI write response
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  // AXI read address
  output logic [ADDR_W-1:0]     araddr,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  // AXI read data
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  // Mask that clears the two byte-offset bits of the request address.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

  bridge_state_t           r_state;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic [DATA_W/8-1:0]     r_wstrb;
  logic                    r_aw_done;
  logic                    r_w_done;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_arvalid;
  logic                    r_data_ready;
  logic                    r_data_err;
  logic [DATA_W-1:0]       r_data_in;

  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_aw_complete;
  logic                    w_w_complete;

  // A write channel counts as complete if it finished on an earlier edge
  // or is finishing on this one.
  assign w_aw_hs       = r_awvalid & awready;
  assign w_w_hs        = r_wvalid & wready;
  assign w_aw_complete = r_aw_done | w_aw_hs;
  assign w_w_complete  = r_w_done | w_w_hs;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_data_ready <= 1'b0;
      r_data_err   <= 1'b0;
      r_data_in    <= '0;
    end else begin
      // Completion flags are pulses; they only rise on the finishing edge.
      r_data_ready <= 1'b0;
      r_data_err   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (en_data) begin
            r_addr    <= addr_data & ALIGN_MASK;
            r_wdata   <= data_out_data;
            r_wstrb   <= we_data;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (we_data != '0) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          // AW and W may complete in either order or together.
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_complete && w_w_complete) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bvalid) begin
            r_data_ready <= 1'b1;
            r_data_err   <= (bresp != AXI_RESP_OKAY);
            r_state      <= IDLE;
          end
        end

        RD_REQ: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_state   <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (rvalid) begin
            // Read data is returned even on an error response.
            r_data_in    <= rdata;
            r_data_ready <= 1'b1;
            r_data_err   <= (rresp != AXI_RESP_OKAY);
            r_state      <= IDLE;
          end
        end

        default: begin
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_arvalid <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  // Response-channel readies and busy decode straight from the state
  // register, so they are free of combinational glitches.
  assign bready       = (r_state == WR_RESP);
  assign rready       = (r_state == RD_RESP);
  assign busy         = (r_state != IDLE);

  assign awaddr       = r_addr;
  assign araddr       = r_addr;
  assign wdata        = r_wdata;
  assign wstrb        = r_wstrb;
  assign awvalid      = r_awvalid;
  assign wvalid       = r_wvalid;
  assign arvalid      = r_arvalid;
  assign awprot       = 3'b000;
  assign arprot       = 3'b000;
  assign data_in_data = r_data_in;
  assign data_ready   = r_data_ready;
  assign data_err     = r_data_err;

endmodule

// File: tb/tb_axil_data_bridge.sv
module tb_axil_data_bridge;

  logic        aclk;
  logic        areset;
  logic [31:0] addr_data;
  logic [31:0] data_out_data;
  logic [3:0]  we_data;
  logic        en_data;
  logic [31:0] data_in_data;
  logic        data_ready;
  logic        data_err;
  logic        busy;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int total = 0;
  int bad   = 0;

  axil_data_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .areset(areset),
    .addr_data(addr_data), .data_out_data(data_out_data), .we_data(we_data),
    .en_data(en_data), .data_in_data(data_in_data), .data_ready(data_ready),
    .data_err(data_err), .busy(busy),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Advance through one rising edge and settle 1ns after it.
  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    addr_data = '0; data_out_data = '0; we_data = '0; en_data = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    #2;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin bad++; $display("FAIL reset_valids got=%b want=00000", {awvalid, wvalid, arvalid, bready, rready}); end
    total++; if ({data_ready, data_err} !== 2'b00) begin bad++; $display("FAIL reset_ready_err got=%b want=00", {data_ready, data_err}); end
    total++; if (data_in_data !== 32'h0) begin bad++; $display("FAIL reset_data_in got=%h want=00000000", data_in_data); end
    total++; if ({awaddr, araddr, wdata} !== 96'h0 || wstrb !== 4'h0) begin bad++; $display("FAIL reset_regs awaddr=%h araddr=%h wdata=%h wstrb=%h want all 0", awaddr, araddr, wdata, wstrb); end
    total++; if ({awprot, arprot} !== 6'b0) begin bad++; $display("FAIL prot got=%b want=000000", {awprot, arprot}); end
    step; step;
    areset = 1'b0;
    step;
    $display("reset: busy=%b data_in=%h", busy, data_in_data);
  endtask

  task automatic test_zero_wait_read;
    addr_data = 32'h0000_0104; we_data = 4'b0000; en_data = 1'b1; arready = 1'b1;
    step; en_data = 1'b0;
    // cycle k+1
    total++; if (busy !== 1'b1 || arvalid !== 1'b1) begin bad++; $display("FAIL zrd_k1_busy_arvalid got=%b%b want=11", busy, arvalid); end
    total++; if (araddr !== 32'h0000_0104) begin bad++; $display("FAIL zrd_araddr got=%h want=00000104", araddr); end
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL zrd_k1_ready got=%b want=0", data_ready); end
    step; rvalid = 1'b1; rdata = 32'hCAFE_BABE; rresp = 2'b00;
    // cycle k+2
    total++; if (arvalid !== 1'b0 || rready !== 1'b1) begin bad++; $display("FAIL zrd_k2_arvalid_rready got=%b%b want=01", arvalid, rready); end
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL zrd_k2_ready got=%b want=0", data_ready); end
    step; rvalid = 1'b0;
    // cycle k+3
    total++; if (data_ready !== 1'b1 || data_err !== 1'b0) begin bad++; $display("FAIL zrd_k3_ready_err got=%b%b want=10", data_ready, data_err); end
    total++; if (data_in_data !== 32'hCAFE_BABE) begin bad++; $display("FAIL zrd_data_in got=%h want=cafebabe", data_in_data); end
    total++; if (busy !== 1'b0 || rready !== 1'b0) begin bad++; $display("FAIL zrd_k3_busy_rready got=%b%b want=00", busy, rready); end
    step;
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL zrd_pulse_width got=%b want=0", data_ready); end
    $display("zero-wait read: addr=00000104 data_in=%h", data_in_data);
  endtask

  task automatic test_unaligned_read;
    addr_data = 32'h0000_0107; we_data = 4'b0000; en_data = 1'b1; arready = 1'b1;
    step; en_data = 1'b0;
    total++; if (araddr !== 32'h0000_0104) begin bad++; $display("FAIL unal_araddr got=%h want=00000104", araddr); end
    step; rvalid = 1'b1; rdata = 32'h0BAD_F00D; rresp = 2'b11;
    step; rvalid = 1'b0; rresp = 2'b00;
    total++; if (data_ready !== 1'b1 || data_err !== 1'b1) begin bad++; $display("FAIL unal_decerr got=%b%b want=11", data_ready, data_err); end
    total++; if (data_in_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL unal_data_in_on_err got=%h want=0badf00d", data_in_data); end
    step;
    $display("unaligned read: addr=00000107 araddr=%h data_in=%h", araddr, data_in_data);
  endtask

  task automatic test_write_aw_delayed;
    int aw_cycles = 0, w_cycles = 0, aw_hs = 0, w_hs = 0;
    addr_data = 32'h0000_0200; data_out_data = 32'h1234_5678; we_data = 4'b0011; en_data = 1'b1;
    step; en_data = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wready = 1'b1;
      awready = (i >= 3);
      aw_cycles += int'(awvalid);
      w_cycles  += int'(wvalid);
      aw_hs     += int'(awvalid & awready);
      w_hs      += int'(wvalid & wready);
      total++; if (awaddr !== 32'h0000_0200 || wdata !== 32'h1234_5678 || wstrb !== 4'b0011) begin bad++; $display("FAIL wr_stable cyc=%0d awaddr=%h wdata=%h wstrb=%b want 00000200 12345678 0011", i, awaddr, wdata, wstrb); end
      step;
    end
    awready = 1'b0; wready = 1'b0;
    // cycle k+4: both handshakes done, waiting for B
    total++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin bad++; $display("FAIL wr_k4 aw/w/bready got=%b%b%b want=001", awvalid, wvalid, bready); end
    total++; if (aw_cycles != 3 || w_cycles != 1) begin bad++; $display("FAIL wr_valid_cycles aw=%0d w=%0d want aw=3 w=1", aw_cycles, w_cycles); end
    total++; if (aw_hs != 1 || w_hs != 1) begin bad++; $display("FAIL wr_handshakes aw=%0d w=%0d want 1 1", aw_hs, w_hs); end
    bvalid = 1'b1; bresp = 2'b00;
    step; bvalid = 1'b0;
    total++; if (data_ready !== 1'b1 || data_err !== 1'b0) begin bad++; $display("FAIL wr_ready_err got=%b%b want=10", data_ready, data_err); end
    total++; if (data_in_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL wr_data_in_unchanged got=%h want=0badf00d", data_in_data); end
    step;
    $display("write aw-delayed: aw_cycles=%0d w_cycles=%0d data_in=%h", aw_cycles, w_cycles, data_in_data);
  endtask

  task automatic test_write_slverr;
    addr_data = 32'h0000_0208; data_out_data = 32'hDEAD_BEEF; we_data = 4'b1111; en_data = 1'b1;
    awready = 1'b1; wready = 1'b1;
    step; en_data = 1'b0;
    total++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin bad++; $display("FAIL slv_k1_valids got=%b%b want=11", awvalid, wvalid); end
    step; awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bvalid = 1'b0;
      total++; if (bready !== 1'b1 || data_ready !== 1'b0) begin bad++; $display("FAIL slv_wait cyc=%0d bready/ready got=%b%b want=10", i, bready, data_ready); end
      step;
    end
    bvalid = 1'b1; bresp = 2'b10;
    step; bvalid = 1'b0; bresp = 2'b00;
    total++; if (data_ready !== 1'b1 || data_err !== 1'b1) begin bad++; $display("FAIL slv_ready_err got=%b%b want=11", data_ready, data_err); end
    step;
    total++; if (busy !== 1'b0 || data_ready !== 1'b0 || data_err !== 1'b0) begin bad++; $display("FAIL slv_after busy/ready/err got=%b%b%b want=000", busy, data_ready, data_err); end
    $display("write slverr: data_err seen, busy=%b", busy);
  endtask

  task automatic test_back_to_back;
    int ar_hs = 0, dr = 0;
    addr_data = 32'h0000_0300; we_data = 4'b0000; en_data = 1'b1; arready = 1'b1;
    step;
    for (int i = 1; i <= 8; i++) begin
      rvalid = (i == 7);
      rdata = 32'h1111_2222;
      ar_hs += int'(arvalid & arready);
      dr    += int'(data_ready);
      if (i == 8) begin
        total++; if (data_ready !== 1'b1 || arvalid !== 1'b0) begin bad++; $display("FAIL b2b_k8 ready/arvalid got=%b%b want=10", data_ready, arvalid); end
        total++; if (data_in_data !== 32'h1111_2222) begin bad++; $display("FAIL b2b_data1 got=%h want=11112222", data_in_data); end
      end
      step;
    end
    rvalid = 1'b0;
    total++; if (ar_hs != 1 || dr != 1) begin bad++; $display("FAIL b2b_counts ar_hs=%0d ready_pulses=%0d want 1 1", ar_hs, dr); end
    total++; if (arvalid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL b2b_reaccept arvalid/busy got=%b%b want=11", arvalid, busy); end
    en_data = 1'b0;
    step; rvalid = 1'b1; rdata = 32'h3333_4444;
    step; rvalid = 1'b0;
    total++; if (data_ready !== 1'b1 || data_in_data !== 32'h3333_4444) begin bad++; $display("FAIL b2b_second ready=%b data=%h want 1 33334444", data_ready, data_in_data); end
    step;
    $display("back-to-back: ar_hs=%0d pulses=%0d data_in=%h", ar_hs, dr, data_in_data);
  endtask

  task automatic test_reset_mid_read;
    addr_data = 32'h0000_0400; we_data = 4'b0000; en_data = 1'b1; arready = 1'b1;
    step; en_data = 1'b0;
    step;
    total++; if (rready !== 1'b1) begin bad++; $display("FAIL rst_pre_rready got=%b want=1", rready); end
    #2; areset = 1'b1;
    #1;
    total++; if (rready !== 1'b0 || busy !== 1'b0 || arvalid !== 1'b0) begin bad++; $display("FAIL rst_async rready/busy/arvalid got=%b%b%b want=000", rready, busy, arvalid); end
    total++; if (data_in_data !== 32'h0) begin bad++; $display("FAIL rst_async_data_in got=%h want=00000000", data_in_data); end
    #1; areset = 1'b0;
    step; step;
    addr_data = 32'h0000_0500; en_data = 1'b1;
    step; en_data = 1'b0;
    total++; if (arvalid !== 1'b1 || araddr !== 32'h0000_0500) begin bad++; $display("FAIL rst_next_ar arvalid=%b araddr=%h want 1 00000500", arvalid, araddr); end
    step; rvalid = 1'b1; rdata = 32'h5555_AAAA; rresp = 2'b00;
    step; rvalid = 1'b0;
    total++; if (data_ready !== 1'b1 || data_in_data !== 32'h5555_AAAA) begin bad++; $display("FAIL rst_next_done ready=%b data=%h want 1 5555aaaa", data_ready, data_in_data); end
    step;
    $display("reset mid-read then read: data_in=%h", data_in_data);
  endtask

  initial begin
    test_reset;
    test_zero_wait_read;
    test_unaligned_read;
    test_write_aw_delayed;
    test_write_slverr;
    test_back_to_back;
    test_reset_mid_read;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_data_bridge.md
# axil_data_bridge

Bridges the CPU core's BRAM-style data port (`addr_data`, `data_out_data`, `we_data`, `en_data`, `data_in_data`) to an AXI4-Lite master interface. It sits directly downstream of the CPU data port and issues one single-beat AXI4-Lite transaction per accepted request. Completion is reported with a `data_ready` pulse so the core can stall its MEMORY state until the transaction finishes.

## Interface
Parameters:
- `ADDR_W`, 32: address width, both CPU side and AXI side.
- `DATA_W`, 32: data width. Fixed at 32; `we_data` and `wstrb` are `DATA_W/8` bits wide.

Ports:
- `aclk`  in  1  sole clock. All logic is rising-edge.
- `areset`  in  1  asynchronous, active-high reset.
- `addr_data`  in  ADDR_W  byte address of the request.
- `data_out_data`  in  DATA_W  write data from the core.
- `we_data`  in  4  byte write enables. Nonzero means write; zero means read.
- `en_data`  in  1  request strobe. Sampled only in IDLE.
- `data_in_data`  out  DATA_W  read data returned to the core. Registered.
- `data_ready`  out  1  one-cycle completion pulse.
- `data_err`  out  1  error flag, valid only while `data_ready`=1.
- `busy`  out  1  high in every state except IDLE.
- `awaddr` out ADDR_W, `awprot` out 3, `awvalid` out 1, `awready` in 1: AXI write address channel.
- `wdata` out DATA_W, `wstrb` out 4, `wvalid` out 1, `wready` in 1: AXI write data channel.
- `bresp` in 2, `bvalid` in 1, `bready` out 1: AXI write response channel.
- `araddr` out ADDR_W, `arprot` out 3, `arvalid` out 1, `arready` in 1: AXI read address channel.
- `rdata` in DATA_W, `rresp` in 2, `rvalid` in 1, `rready` out 1: AXI read data channel.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE:
  - If `en_data`=1, capture the address with bits [1:0] forced to 0, plus `data_out_data` and `we_data`.
  - If `we_data`!=0, go to WR_REQ. Otherwise go to RD_REQ.
- WR_REQ:
  - `awvalid` and `wvalid` assert together on entry.
  - Each deasserts independently on the edge where its own handshake completes.
  - `awaddr`, `wdata` and `wstrb` stay stable while their valid is high.
  - When both handshakes have completed (in either order, or on the same edge), go to WR_RESP.
- WR_RESP:
  - `bready`=1.
  - On `bvalid`&`bready`, pulse `data_ready`, set `data_err` = (`bresp`!=OKAY), and return to IDLE.
  - `data_in_data` is unchanged on write completion.
- RD_REQ:
  - `arvalid`=1, held until `arready`.
  - Then go to RD_RESP.
- RD_RESP:
  - `rready`=1.
  - On `rvalid`&`rready`, register `rdata` into `data_in_data`, pulse `data_ready`, set `data_err` = (`rresp`!=OKAY), and return to IDLE.
  - `data_in_data` is loaded even when `rresp` is an error.
- `awprot` and `arprot` are constant 3'b000.
- `en_data` outside IDLE is ignored. The core must not re-issue until it sees `data_ready`.
- Valid signals are never withdrawn before their handshake completes (AXI rule).
- No outstanding transactions: at most one transaction is in flight.

## Timing
- Reset values, applied immediately on `areset` assertion:
  - state IDLE
  - all valid and ready outputs 0
  - `data_ready`=0, `data_err`=0, `busy`=0
  - `data_in_data`=0, address and data registers 0
- Reset mid-transaction returns to IDLE and drops all valids. Any AXI transaction in progress is abandoned; the system resets the slave together with the bridge.
- `en_data` sampled at edge k:
  - `busy` and the request valid(s) rise in cycle k+1.
  - With a zero-wait slave (ready=1, response in the cycle after the handshake), `data_ready` is high in cycle k+3.
- `data_ready` is high for exactly one cycle.
- IDLE accepts a new `en_data` in the cycle after `data_ready`, so back-to-back requests are spaced 3 cycles apart minimum.
- `bready` and `rready` are decoded from the registered state and are glitch-free.

## Structure
- `cpu_pkg` holds:
  - the `bridge_state_t` enum (IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP)
  - localparams `AXI_RESP_OKAY`=2'b00, `AXI_RESP_SLVERR`=2'b10, `AXI_RESP_DECERR`=2'b11
- The block is a single module with no sub-modules. Two flags (`aw_done`, `w_done`) track the independent write-channel handshakes.

## Test plan
- Zero-wait read: `addr_data`=0x0000_0104, `we_data`=0, `rdata`=0xCAFE_BABE → `araddr`=0x104, `data_ready` in cycle k+3, `data_in_data`=0xCAFE_BABE, `data_err`=0.
- Unaligned read: `addr_data`=0x0000_0107 → `araddr`=0x0000_0104.
- Write, `we_data`=4'b0011, `data_out_data`=0x1234_5678, `wready` immediate, `awready` delayed 2 cycles:
  - `wvalid` drops after 1 cycle.
  - `awvalid` holds 3 cycles.
  - `wstrb`=4'b0011.
  - Exactly one AW and one W handshake.
  - `data_in_data` unchanged.
- Write with `bresp`=SLVERR after 4 wait cycles → `data_ready` and `data_err` both 1 in the same single cycle; `busy`=0 in the next cycle.
- `en_data` held high throughout a read with `rvalid` delayed 5 cycles → exactly one AR handshake, one `data_ready` pulse, and a new request accepted only after it.
- `areset` pulsed during RD_RESP → `rready`, `busy` and `data_in_data` go to 0 without waiting for a clock edge; the next read completes normally.
